// File: rtl/spi_flash_responder_if.sv
// SPI flash link bundle: serial lines from the controller plus the target's status pins.
// Latency: none (wires only).
// Backpressure: none; SPI is controller-paced, the target never stalls the link.
//
// Signals:
//   sclk   controller -> target  SPI clock, idle low (mode 0)
//   cs_n   controller -> target  chip select, active low
//   mosi   controller -> target  serial data, MSB first
//   miso   target -> controller  serial data, MSB first
//   wip    target -> controller  write-in-progress status bit
//   wel    target -> controller  write-enable-latch status bit
interface spi_flash_responder_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic wip;
  logic wel;

  modport master (output sclk, cs_n, mosi, input miso, wip, wel);
  modport slave  (input sclk, cs_n, mosi, output miso, wip, wel);
endinterface

// File: rtl/spi_flash_responder.sv
// Small NOR-flash emulator on a mode-0 SPI link: READ/PP/RDSR/WREN/WRDI served from an internal byte array.
// Latency: miso changes 3-4 clk after the sclk fall that shifts it; 2-flop synchronisers on all SPI inputs.
// Backpressure: none; the controller paces everything. Commands other than RDSR are ignored while wip=1.
//
// Ports:
//   clk    system clock, at least 6x the sclk frequency
//   rst_n  asynchronous active-low reset (memory array is not reset)
//   spi    slave modport: sclk/cs_n/mosi in, miso/wip/wel out
module spi_flash_responder #(
  parameter int MEM_BYTES   = 256,
  parameter int BUSY_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  spi_flash_responder_if.slave         spi
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int BW = $clog2(BUSY_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RDATA,
    ST_WDATA,
    ST_STATUS,
    ST_IGNORE
  } state_t;

  // Input synchronisers and edge detection
  logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic       sclk_prev_q, cs_prev_q;
  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_fall;

  assign sclk_s    = sclk_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  // Protocol state
  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     sh_in_q, sh_in_d;
  logic [7:0]     sh_out_q, sh_out_d;
  logic           miso_q, miso_d;
  logic [23:0]    addr_q, addr_d;
  logic [1:0]     addr_cnt_q, addr_cnt_d;
  logic           is_wr_q, is_wr_d;
  logic           pp_wr_q, pp_wr_d;
  logic           wip_q, wip_d;
  logic           wel_q, wel_d;
  logic [BW-1:0]  busy_q, busy_d;

  logic [7:0]     mem [MEM_BYTES];
  logic [AW-1:0]  idx;
  logic [7:0]     mem_rd;
  logic [7:0]     byte_in;
  logic [7:0]     load_byte;
  logic           byte_done;
  logic           mem_we;

  assign idx       = addr_q[AW-1:0];
  assign mem_rd    = mem[idx];
  // Byte as it stands after the current rising edge's sample is shifted in.
  assign byte_in   = {sh_in_q[6:0], mosi_s};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

  assign spi.miso = miso_q;
  assign spi.wip  = wip_q;
  assign spi.wel  = wel_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sh_in_d    = sh_in_q;
    sh_out_d   = sh_out_q;
    miso_d     = miso_q;
    addr_d     = addr_q;
    addr_cnt_d = addr_cnt_q;
    is_wr_d    = is_wr_q;
    pp_wr_d    = pp_wr_q;
    wip_d      = wip_q;
    wel_d      = wel_q;
    busy_d     = busy_q;
    mem_we     = 1'b0;
    load_byte  = 8'h00;

    // Program-busy countdown; expiry also drops the write-enable latch.
    if (busy_q != '0) begin
      busy_d = busy_q - 1'b1;
      if (busy_q == BW'(1)) begin
        wip_d = 1'b0;
        wel_d = 1'b0;
      end
    end

    if (cs_s) begin
      // Deselect overrides any sclk edge seen in the same cycle.
      if (state_q == ST_WDATA && pp_wr_q) begin
        wip_d  = 1'b1;
        busy_d = BW'(BUSY_CYCLES);
      end
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      sh_in_d   = 8'h00;
      miso_d    = 1'b0;
      pp_wr_d   = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (cs_fall) begin
        state_d   = ST_CMD;
        bit_cnt_d = 3'd0;
      end
    end else begin
      if (sclk_rise) begin
        sh_in_d   = byte_in;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end

      if (byte_done) begin
        unique case (state_q)
          ST_CMD: begin
            if (wip_q && byte_in != 8'h05) begin
              state_d = ST_IGNORE;
            end else begin
              unique case (byte_in)
                8'h03: begin
                  state_d    = ST_ADDR;
                  is_wr_d    = 1'b0;
                  addr_cnt_d = 2'd0;
                end
                8'h02: begin
                  if (wel_q) begin
                    state_d    = ST_ADDR;
                    is_wr_d    = 1'b1;
                    addr_cnt_d = 2'd0;
                  end else begin
                    state_d = ST_IGNORE;
                  end
                end
                8'h05: state_d = ST_STATUS;
                8'h06: begin
                  wel_d   = 1'b1;
                  state_d = ST_IGNORE;
                end
                8'h04: begin
                  wel_d   = 1'b0;
                  state_d = ST_IGNORE;
                end
                default: state_d = ST_IGNORE;
              endcase
            end
          end
          ST_ADDR: begin
            addr_d     = {addr_q[15:0], byte_in};
            addr_cnt_d = addr_cnt_q + 2'd1;
            if (addr_cnt_q == 2'd2) begin
              state_d = is_wr_q ? ST_WDATA : ST_RDATA;
              pp_wr_d = 1'b0;
            end
          end
          ST_WDATA: begin
            mem_we  = 1'b1;
            // Page program wraps within the 256-byte page.
            addr_d  = {addr_q[23:8], addr_q[7:0] + 8'd1};
            pp_wr_d = 1'b1;
          end
          default: ;
        endcase
      end

      // The fall that follows a completed byte (bit counter back at 0) loads the next outgoing byte.
      if (sclk_fall && (state_q == ST_RDATA || state_q == ST_STATUS)) begin
        if (bit_cnt_q == 3'd0) begin
          if (state_q == ST_RDATA) begin
            load_byte = mem_rd;
            addr_d    = 24'(idx + AW'(1));
          end else begin
            load_byte = {6'b0, wel_q, wip_q};
          end
          miso_d   = load_byte[7];
          sh_out_d = {load_byte[6:0], 1'b0};
        end else begin
          miso_d   = sh_out_q[7];
          sh_out_d = {sh_out_q[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      sh_in_q     <= 8'h00;
      sh_out_q    <= 8'h00;
      miso_q      <= 1'b0;
      addr_q      <= 24'h0;
      addr_cnt_q  <= 2'd0;
      is_wr_q     <= 1'b0;
      pp_wr_q     <= 1'b0;
      wip_q       <= 1'b0;
      wel_q       <= 1'b0;
      busy_q      <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi.sclk};
      cs_sync_q   <= {cs_sync_q[0], spi.cs_n};
      mosi_sync_q <= {mosi_sync_q[0], spi.mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_in_q     <= sh_in_d;
      sh_out_q    <= sh_out_d;
      miso_q      <= miso_d;
      addr_q      <= addr_d;
      addr_cnt_q  <= addr_cnt_d;
      is_wr_q     <= is_wr_d;
      pp_wr_q     <= pp_wr_d;
      wip_q       <= wip_d;
      wel_q       <= wel_d;
      busy_q      <= busy_d;
    end
  end

  // Array is deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= byte_in;
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: drives a mode-0 SPI controller and checks returned bytes and status pins.
// Latency: sclk half-period is 8 clk so miso is settled well before each rising edge.
// Backpressure: none.
module tb_spi_flash_responder;

  localparam int BUSY = 2000;
  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] rx;
  logic [7:0] r0, r1, r2;
  int   n;

  always #5 clk = ~clk;

  spi_flash_responder_if spi ();

  spi_flash_responder #(
    .MEM_BYTES   (256),
    .BUSY_CYCLES (BUSY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .spi   (spi)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Shift nbits of tx (MSB first) out; capture miso just before each rising edge.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
    rxb = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi.mosi = tx[i];
      #(HALF);
      rxb[i] = spi.miso;
      spi.sclk = 1'b1;
      #(HALF);
      spi.sclk = 1'b0;
    end
  endtask

  task automatic cs_start();
    spi.cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic cs_end();
    #(HALF);
    spi.cs_n = 1'b1;
    #(2 * HALF);
  endtask

  task automatic send_cmd(input logic [7:0] op);
    logic [7:0] d;
    cs_start();
    xfer(op, 8, d);
    cs_end();
  endtask

  task automatic rdsr(output logic [7:0] s);
    logic [7:0] d;
    cs_start();
    xfer(8'h05, 8, d);
    xfer(8'h00, 8, s);
    cs_end();
  endtask

  // Opcode plus 3 address bytes; caller keeps cs_n low.
  task automatic hdr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] d;
    xfer(op, 8, d);
    xfer(a[23:16], 8, d);
    xfer(a[15:8], 8, d);
    xfer(a[7:0], 8, d);
  endtask

  initial begin
    spi.sclk = 1'b0;
    spi.cs_n = 1'b1;
    spi.mosi = 1'b0;
    rst_n    = 1'b0;
    #20;
    check("rst_miso", {31'b0, spi.miso}, 32'd0);
    check("rst_wip", {31'b0, spi.wip}, 32'd0);
    check("rst_wel", {31'b0, spi.wel}, 32'd0);
    #20;
    rst_n = 1'b1;
    #40;

    // RDSR after reset, two status bytes
    cs_start();
    xfer(8'h05, 8, rx);
    xfer(8'h00, 8, r0);
    xfer(8'h00, 8, r1);
    cs_end();
    check("rdsr_reset_b0", {24'b0, r0}, 32'h00);
    check("rdsr_reset_b1", {24'b0, r1}, 32'h00);

    // WREN then status
    send_cmd(8'h06);
    check("wren_wel_pin", {31'b0, spi.wel}, 32'd1);
    rdsr(rx);
    check("rdsr_after_wren", {24'b0, rx}, 32'h02);

    // Page program at 0x10
    cs_start();
    hdr(8'h02, 24'h000010);
    xfer(8'hA5, 8, rx);
    xfer(8'h5A, 8, rx);
    xfer(8'hC3, 8, rx);
    cs_end();
    check("pp_wip_pin", {31'b0, spi.wip}, 32'd1);
    rdsr(rx);
    check("rdsr_busy", {24'b0, rx}, 32'h03);

    // While busy: WREN/WRDI/READ have no effect, RDSR still answers
    send_cmd(8'h06);
    check("busy_wren_wel", {31'b0, spi.wel}, 32'd1);
    send_cmd(8'h04);
    check("busy_wrdi_wel", {31'b0, spi.wel}, 32'd1);
    cs_start();
    hdr(8'h03, 24'h000010);
    xfer(8'h00, 8, rx);
    cs_end();
    check("busy_read_miso", {24'b0, rx}, 32'h00);
    rdsr(rx);
    check("rdsr_busy_again", {24'b0, rx}, 32'h03);

    n = 0;
    while (spi.wip === 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("busy_ends_wip", {31'b0, spi.wip}, 32'd0);
    check("busy_ends_wel", {31'b0, spi.wel}, 32'd0);
    rdsr(rx);
    check("rdsr_idle", {24'b0, rx}, 32'h00);

    // Read back the programmed bytes
    cs_start();
    hdr(8'h03, 24'h000010);
    xfer(8'h00, 8, r0);
    xfer(8'h00, 8, r1);
    xfer(8'h00, 8, r2);
    cs_end();
    check("read10_b0", {24'b0, r0}, 32'hA5);
    check("read10_b1", {24'b0, r1}, 32'h5A);
    check("read10_b2", {24'b0, r2}, 32'hC3);

    // PP without WREN is dropped
    cs_start();
    hdr(8'h02, 24'h000020);
    xfer(8'h11, 8, rx);
    cs_end();
    check("nowren_pp_wip", {31'b0, spi.wip}, 32'd0);
    cs_start();
    hdr(8'h03, 24'h000020);
    xfer(8'h00, 8, rx);
    cs_end();
    checks++;
    assert (rx !== 8'h11) else begin
      errors++;
      $error("FAIL nowren_pp_mem: observed=%0h expected=not 11", rx);
    end

    // PP at 0xFE wraps within the page; measure busy length
    send_cmd(8'h06);
    cs_start();
    hdr(8'h02, 24'h0000FE);
    xfer(8'h77, 8, rx);
    xfer(8'h88, 8, rx);
    xfer(8'h99, 8, rx);
    #(HALF);
    spi.cs_n = 1'b1;
    n = 0;
    while (spi.wip !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pp_wip_rise", {31'b0, spi.wip}, 32'd1);
    n = 0;
    while (spi.wip === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("pp_busy_len", n, BUSY);
    check("pp_done_wel", {31'b0, spi.wel}, 32'd0);

    cs_start();
    hdr(8'h03, 24'h0000FF);
    xfer(8'h00, 8, r0);
    xfer(8'h00, 8, r1);
    cs_end();
    check("readFF_b0", {24'b0, r0}, 32'h88);
    check("readFF_wrap_b1", {24'b0, r1}, 32'h99);
    cs_start();
    hdr(8'h03, 24'h0000FE);
    xfer(8'h00, 8, r0);
    cs_end();
    check("readFE", {24'b0, r0}, 32'h77);

    // Partial data byte: no write, no busy, wel kept
    send_cmd(8'h06);
    cs_start();
    hdr(8'h02, 24'h000012);
    xfer(8'hFF, 4, rx);
    cs_end();
    check("partial_wip", {31'b0, spi.wip}, 32'd0);
    check("partial_wel", {31'b0, spi.wel}, 32'd1);
    cs_start();
    hdr(8'h03, 24'h000012);
    xfer(8'h00, 8, rx);
    cs_end();
    check("partial_mem", {24'b0, rx}, 32'hC3);

    // Reset in the middle of a READ
    cs_start();
    hdr(8'h03, 24'h000010);
    xfer(8'h00, 3, rx);
    rst_n = 1'b0;
    #20;
    check("midrst_miso", {31'b0, spi.miso}, 32'd0);
    check("midrst_wel", {31'b0, spi.wel}, 32'd0);
    check("midrst_wip", {31'b0, spi.wip}, 32'd0);
    rst_n = 1'b1;
    #20;
    cs_end();
    cs_start();
    hdr(8'h03, 24'h000010);
    xfer(8'h00, 8, r0);
    xfer(8'h00, 8, r1);
    cs_end();
    check("post_rst_read_b0", {24'b0, r0}, 32'hA5);
    check("post_rst_read_b1", {24'b0, r1}, 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
